// File: rtl/scaled_normalizer.sv
// Renormalises a scaled result {scale[2:0], signed mantissa[12:0]}. It shifts the
// mantissa left one bit per cycle until no redundant sign bit is left or the scale saturates.
module scaled_normalizer #(
  parameter int MAX_SCALE = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_invalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_invalid,
  output logic [2:0]  out_shift,
  output logic [1:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // The producer holds valid and data until that edge. The consumer may drop ready at any time.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MAX_S = 3'(MAX_SCALE);

  state_t      state;
  state_t      state_next;
  logic [12:0] mant;
  logic [2:0]  scale;
  logic        inv;
  logic [2:0]  cnt;
  logic        can_shift;
  logic        in_zero;

  assign in_zero   = (in_data[12:0] == 13'd0);
  // Bits 12 and 11 must agree, so a shift never changes the sign.
  assign can_shift = (mant[12] == mant[11]) && (scale < MAX_S);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_invalid || in_zero) state_next = DONE;
          else                       state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (!can_shift) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mant  <= 13'd0;
      scale <= 3'd0;
      inv   <= 1'b0;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt <= 3'd0;
            inv <= in_invalid;
            // Zero is emitted as 16'h0000 no matter what its scale was. Flagged items pass through unchanged.
            if (!in_invalid && in_zero) begin
              mant  <= 13'd0;
              scale <= 3'd0;
            end else begin
              mant  <= in_data[12:0];
              scale <= in_data[15:13];
            end
          end
        end
        SHIFT: begin
          if (can_shift) begin
            mant  <= {mant[11:0], 1'b0};
            scale <= scale + 3'd1;
            cnt   <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE) && !rst;
  assign out_valid   = (state == DONE);
  assign out_data    = {scale, mant};
  assign out_invalid = inv;
  assign out_shift   = cnt;
  assign fsm_state   = state;

endmodule

// File: doc/scaled_normalizer.md
Name: scaled_normalizer

Overview:
- Sequential stage directly downstream of the carry-select add/sub block.
- Consumes its 16-bit scaled result: [15:13] = scale s, unsigned; [12:0] = signed mantissa m; value = m / 2^s.
- Renormalises the result to regain the precision lost by scale alignment. It shifts the mantissa left one bit per cycle and increments the scale until the mantissa has no redundant sign bit or the scale reaches MAX_SCALE.
- Uses valid/ready handshakes on both sides and holds one item in flight.

Parameters:
MAX_SCALE, 7, highest scale the normaliser may reach (0..7).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data/in_invalid are valid this cycle.
in_ready  output  1  block can accept an item; high only in IDLE.
in_data  input  16  scaled result from add/sub stage: [15:13] scale, [12:0] mantissa.
in_invalid  input  1  overflow flag from add/sub stage.
out_valid  output  1  out_* are valid; held until accepted.
out_ready  input  1  consumer accepts the item this cycle.
out_data  output  16  normalised result, same format as in_data.
out_invalid  output  1  copy of in_invalid for this item.
out_shift  output  3  number of left shifts applied.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- FSM states: IDLE, SHIFT, DONE. Registers: mant[12:0], scale[2:0], inv, cnt[2:0].
- Reset:
  - State goes to IDLE; all registers cleared.
  - out_valid=0, out_data=16'h0000, out_invalid=0, out_shift=0.
  - in_ready=0 while rst is high.
  - Reset mid-operation drops the in-flight item; nothing is emitted.
- IDLE: in_ready=1. On in_valid at edge E0, the item is captured and cnt=0.
  - If in_invalid=1, next state is DONE; data is passed through unchanged.
  - If mantissa==0, next state is DONE; mant=0, scale=0 (canonical zero 16'h0000).
  - Otherwise next state is SHIFT.
- SHIFT: evaluated on each edge.
  - Shift condition: mant[12]==mant[11] and scale<MAX_SCALE.
  - If the condition holds: mant<=mant<<1 (bit0=0), scale<=scale+1, cnt<=cnt+1.
  - Else go to DONE.
  - At most 7 shifts occur; the sign is never lost because a shift only happens when bits 12 and 11 agree.
- DONE:
  - out_valid=1; out_data={scale,mant}, out_invalid=inv, out_shift=cnt.
  - All outputs are registered and stable while out_valid=1 and out_ready=0.
  - On out_ready go to IDLE.
  - in_ready=0 in DONE; no same-cycle refill. Throughput is 1 item per k+3 cycles.
- Latency from the accept edge E0 to out_valid high:
  - k shifts: out_valid visible after edge E0+k+1.
  - Invalid or zero input: visible after E0.
- Inputs scaled above MAX_SCALE: no shift, passed through as-is with out_shift=0.
- in_valid while not in IDLE is ignored; the upstream stage must hold until in_ready.

Test Plan:
- in_data=16'h2003 (s=1, m=3), in_invalid=0 -> 6 shifts; out_data=16'hE0C0 (s=7, m=192), out_shift=6, out_valid after edge E0+7.
- in_data=16'h4800 (s=2, m=2048, already normalised) -> out_data=16'h4800, out_shift=0, out_valid after E0+1.
- in_data=16'h1FFF (s=0, m=-1) -> stops at MAX_SCALE; out_data=16'hFF80 (s=7, m=-128), out_shift=7.
- in_data=16'h6000 (zero, s=3) -> out_data=16'h0000, out_shift=0, out_valid after E0. Separately, in_data=16'h2003 with in_invalid=1 -> out_data=16'h2003, out_invalid=1, out_shift=0.
- Backpressure on 16'h2003: hold out_ready=0 for 5 cycles -> out_data/out_valid stable and in_ready=0 throughout. Release out_ready -> next cycle IDLE with in_ready=1.
- Reset mid-SHIFT: feed 16'h1FFF, assert rst on the 3rd SHIFT edge -> next cycle all outputs 0 and no out_valid. After rst falls, in_ready=1 and a fresh 16'h4800 yields 16'h4800.
